// File: rtl/alu_seq_unit_if.sv
// Command and result bus of alu_seq_unit: the master issues commands, the slave is the ALU.
interface alu_seq_unit_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [7:0]       flags_in;
    logic             c_we;
    logic [WIDTH-1:0] c_data;
    logic             f_we;
    logic [7:0]       f_data;
    logic             busy;

    modport master (
        output cmd_valid, cmd, op, a, b, flags_in,
        input  cmd_ready, c_we, c_data, f_we, f_data, busy
    );

    modport slave (
        input  cmd_valid, cmd, op, a, b, flags_in,
        output cmd_ready, c_we, c_data, f_we, f_data, busy
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Command-driven sequential ALU with C/F register-file write strobes.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts; otherwise shifts iterate one bit per cycle.
module alu_seq_unit #(
    parameter int WIDTH      = 16,
    parameter int SIGNED_CMP = 0
) (
    input  logic          clk,
    input  logic          reset,
    alu_seq_unit_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBB = 4'h3;
    localparam logic [3:0] OP_CMP = 4'h4, OP_INC = 4'h5, OP_DEC = 4'h6, OP_NAND = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8, OP_OR = 4'h9, OP_NOR = 4'hA, OP_XOR = 4'hB;
    localparam logic [3:0] OP_LSH = 4'hC, OP_RSH = 4'hD, OP_ROL = 4'hE, OP_ROR = 4'hF;
    localparam logic [3:0] CMD_NOP = 4'd0, CMD_LATCHOP = 4'd1, CMD_WRITEC = 4'd2, CMD_WRITEF = 4'd3;

    logic [WIDTH-1:0] result_reg;
    logic             result_valid_reg;
    logic [7:0]       flags_reg;
    logic             c_we_reg;
    logic [WIDTH-1:0] c_data_reg;
    logic             f_we_reg;
    logic [7:0]       f_data_reg;

    logic [WIDTH:0]   arith;
    logic [WIDTH-1:0] res_c;
    logic             carry_c, borrow_c, eq_c, gt_c, lt_c;
    logic [SW-1:0]    amt;
    logic             is_shift;

    assign amt      = bus.b[SW-1:0];
    assign is_shift = (bus.op[3:2] == 2'b11);

    always_comb begin
        eq_c = (bus.a == bus.b);
        if (SIGNED_CMP != 0) begin
            gt_c = ($signed(bus.a) > $signed(bus.b));
            lt_c = ($signed(bus.a) < $signed(bus.b));
        end else begin
            gt_c = (bus.a > bus.b);
            lt_c = (bus.a < bus.b);
        end
    end

`ifdef ALU_BARREL_SHIFT_EN
    // The extra bit beyond the data word captures the last bit shifted out.
    logic [WIDTH:0]     lsh_ext, rsh_ext;
    logic [2*WIDTH-1:0] rol_ext, ror_ext;
    assign lsh_ext = {1'b0, bus.a} << amt;
    assign rsh_ext = {bus.a, 1'b0} >> amt;
    assign rol_ext = {bus.a, bus.a} << amt;
    assign ror_ext = {bus.a, bus.a} >> amt;
`endif

    always_comb begin
        arith    = '0;
        res_c    = '0;
        carry_c  = 1'b0;
        borrow_c = 1'b0;
        case (bus.op)
            OP_ADD: begin
                arith   = {1'b0, bus.a} + {1'b0, bus.b};
                res_c   = arith[WIDTH-1:0];
                carry_c = arith[WIDTH];
            end
            OP_ADC: begin
                arith   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.flags_in[0]};
                res_c   = arith[WIDTH-1:0];
                carry_c = arith[WIDTH];
            end
            OP_SUB, OP_CMP: begin
                arith    = {1'b0, bus.a} - {1'b0, bus.b};
                res_c    = arith[WIDTH-1:0];
                borrow_c = arith[WIDTH];
            end
            OP_SBB: begin
                arith    = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.flags_in[5]};
                res_c    = arith[WIDTH-1:0];
                borrow_c = arith[WIDTH];
            end
            OP_INC: begin
                arith   = {1'b0, bus.a} + {{WIDTH{1'b0}}, 1'b1};
                res_c   = arith[WIDTH-1:0];
                carry_c = arith[WIDTH];
            end
            OP_DEC: begin
                arith    = {1'b0, bus.a} - {{WIDTH{1'b0}}, 1'b1};
                res_c    = arith[WIDTH-1:0];
                borrow_c = (bus.a == '0);
            end
            OP_NAND: res_c = ~(bus.a & bus.b);
            OP_AND:  res_c = bus.a & bus.b;
            OP_OR:   res_c = bus.a | bus.b;
            OP_NOR:  res_c = ~(bus.a | bus.b);
            OP_XOR:  res_c = bus.a ^ bus.b;
            OP_LSH, OP_RSH, OP_ROL, OP_ROR: begin
`ifdef ALU_BARREL_SHIFT_EN
                case (bus.op[1:0])
                    2'b00: {carry_c, res_c} = lsh_ext;
                    2'b01: {res_c, carry_c} = rsh_ext;
                    2'b10: begin
                        res_c   = rol_ext[2*WIDTH-1:WIDTH];
                        carry_c = (amt != '0) & res_c[0];
                    end
                    default: begin
                        res_c   = ror_ext[WIDTH-1:0];
                        carry_c = (amt != '0) & res_c[WIDTH-1];
                    end
                endcase
`else
                // Only zero-amount shifts complete here; the rest go through SHIFT.
                res_c = bus.a;
`endif
            end
            default: res_c = '0;
        endcase
    end

`ifndef ALU_BARREL_SHIFT_EN
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] sh_reg;
    logic [1:0]       sh_op_reg;
    logic [SW-1:0]    cnt_reg;
    logic [2:0]       cmp_reg;
    logic [WIDTH-1:0] step_res;
    logic             step_c;

    always_comb begin
        step_res = sh_reg;
        step_c   = 1'b0;
        case (sh_op_reg)
            2'b00: begin step_res = {sh_reg[WIDTH-2:0], 1'b0};         step_c = sh_reg[WIDTH-1]; end
            2'b01: begin step_res = {1'b0, sh_reg[WIDTH-1:1]};         step_c = sh_reg[0];       end
            2'b10: begin step_res = {sh_reg[WIDTH-2:0], sh_reg[WIDTH-1]}; step_c = sh_reg[WIDTH-1]; end
            default: begin step_res = {sh_reg[0], sh_reg[WIDTH-1:1]};  step_c = sh_reg[0];       end
        endcase
    end

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.busy      = (state_reg == SHIFT);
`else
    assign bus.cmd_ready = 1'b1;
    assign bus.busy      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            flags_reg        <= '0;
            c_we_reg         <= 1'b0;
            c_data_reg       <= '0;
            f_we_reg         <= 1'b0;
            f_data_reg       <= '0;
`ifndef ALU_BARREL_SHIFT_EN
            state_reg        <= IDLE;
            sh_reg           <= '0;
            sh_op_reg        <= '0;
            cnt_reg          <= '0;
            cmp_reg          <= '0;
`endif
        end else begin
            c_we_reg <= 1'b0;
            f_we_reg <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            if (state_reg == SHIFT) begin
                sh_reg  <= step_res;
                cnt_reg <= cnt_reg - SW'(1);
                if (cnt_reg == SW'(1)) begin
                    state_reg        <= IDLE;
                    result_reg       <= step_res;
                    result_valid_reg <= 1'b1;
                    flags_reg        <= {3'b000, cmp_reg, (step_res == '0), step_c};
                end
            end else
`endif
            if (bus.cmd_valid) begin
                case (bus.cmd)
                    CMD_NOP: ;
                    CMD_LATCHOP: begin
`ifndef ALU_BARREL_SHIFT_EN
                        if (is_shift && (amt != '0)) begin
                            state_reg <= SHIFT;
                            sh_reg    <= bus.a;
                            sh_op_reg <= bus.op[1:0];
                            cnt_reg   <= amt;
                            cmp_reg   <= {lt_c, gt_c, eq_c};
                        end else
`endif
                        if (bus.op == OP_CMP) begin
                            // Zero reflects a-b; the error bit survives a compare.
                            flags_reg <= {flags_reg[7], 1'b0, borrow_c, lt_c, gt_c, eq_c,
                                          (res_c == '0), 1'b0};
                        end else begin
                            result_reg       <= res_c;
                            result_valid_reg <= 1'b1;
                            flags_reg        <= {2'b00, borrow_c, lt_c, gt_c, eq_c,
                                                 (res_c == '0), carry_c};
                        end
                    end
                    CMD_WRITEC: begin
                        if (result_valid_reg) begin
                            c_we_reg   <= 1'b1;
                            c_data_reg <= result_reg;
                        end else begin
                            flags_reg[7] <= 1'b1;
                        end
                    end
                    CMD_WRITEF: begin
                        f_we_reg   <= 1'b1;
                        f_data_reg <= flags_reg;
                    end
                    default: flags_reg[7] <= 1'b1;
                endcase
            end
        end
    end

    assign bus.c_we   = c_we_reg;
    assign bus.c_data = c_data_reg;
    assign bus.f_we   = f_we_reg;
    assign bus.f_data = f_data_reg;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed plus random bench for alu_seq_unit: a 16-bit unsigned-compare instance and an 8-bit signed one.
module tb_alu_seq_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_seq_unit_if #(.WIDTH(16)) if16 ();
    alu_seq_unit_if #(.WIDTH(8))  if8 ();

    alu_seq_unit #(.WIDTH(16), .SIGNED_CMP(0)) dut16 (.clk(clk), .reset(reset), .bus(if16));
    alu_seq_unit #(.WIDTH(8),  .SIGNED_CMP(1)) dut8  (.clk(clk), .reset(reset), .bus(if8));

    typedef struct {
        logic [63:0] result;
        bit          valid;
        logic [7:0]  flags;
    } mstate_t;

    typedef struct {
        logic        ready, busy, c_we, f_we;
        logic [63:0] c_data;
        logic [7:0]  f_data;
    } obs_t;

    mstate_t m[2];   // index 0: 16-bit unsigned instance, 1: 8-bit signed instance
    int checks = 0;
    int fails  = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t sample(bit sel);
        obs_t o;
        if (sel) begin
            o.ready = if8.cmd_ready; o.busy = if8.busy; o.c_we = if8.c_we; o.f_we = if8.f_we;
            o.c_data = {56'd0, if8.c_data}; o.f_data = if8.f_data;
        end else begin
            o.ready = if16.cmd_ready; o.busy = if16.busy; o.c_we = if16.c_we; o.f_we = if16.f_we;
            o.c_data = {48'd0, if16.c_data}; o.f_data = if16.f_data;
        end
        return o;
    endfunction

    task automatic drive(bit sel, logic v, logic [3:0] cmd, logic [3:0] op,
                         logic [63:0] a, logic [63:0] b, logic [7:0] fin);
        if (sel) begin
            if8.cmd_valid = v; if8.cmd = cmd; if8.op = op;
            if8.a = a[7:0]; if8.b = b[7:0]; if8.flags_in = fin;
        end else begin
            if16.cmd_valid = v; if16.cmd = cmd; if16.op = op;
            if16.a = a[15:0]; if16.b = b[15:0]; if16.flags_in = fin;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].result = '0; m[i].valid = 1'b0; m[i].flags = '0;
        end
    endtask

    // Reference behaviour from plain arithmetic on unbounded integers, masked to width.
    task automatic model_latch(bit sel, logic [3:0] op, logic [63:0] a_in, logic [63:0] b_in,
                               logic [7:0] fin, output int lat);
        int w = sel ? 8 : 16;
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned a = a_in & mask;
        longint unsigned b = b_in & mask;
        longint unsigned res = 0, full = 0;
        int k = int'(b % longint'(w));
        longint sa = longint'(a), sb = longint'(b);
        bit carry = 0, borrow = 0, eq, gt, lt;
        if (sel) begin
            if (a > (mask >> 1)) sa = longint'(a) - longint'(mask + 1);
            if (b > (mask >> 1)) sb = longint'(b) - longint'(mask + 1);
        end
        eq = (a == b); gt = (sa > sb); lt = (sa < sb);
        case (op)
            4'd0: begin full = a + b; res = full & mask; carry = (full > mask); end
            4'd1: begin full = a + b + fin[0]; res = full & mask; carry = (full > mask); end
            4'd2, 4'd4: begin res = (a - b) & mask; borrow = (a < b); end
            4'd3: begin res = (a - b - fin[5]) & mask; borrow = (a < b + fin[5]); end
            4'd5: begin full = a + 1; res = full & mask; carry = (full > mask); end
            4'd6: begin res = (a - 1) & mask; borrow = (a == 0); end
            4'd7: res = ~(a & b) & mask;
            4'd8: res = a & b;
            4'd9: res = a | b;
            4'd10: res = ~(a | b) & mask;
            4'd11: res = a ^ b;
            4'd12: begin res = (a << k) & mask; carry = (k > 0) && (((a >> (w - k)) & 1) != 0); end
            4'd13: begin res = a >> k; carry = (k > 0) && (((a >> (k - 1)) & 1) != 0); end
            4'd14: begin
                res = (k > 0) ? (((a << k) | (a >> (w - k))) & mask) : a;
                carry = (k > 0) && ((res & 1) != 0);
            end
            default: begin
                res = (k > 0) ? (((a >> k) | (a << (w - k))) & mask) : a;
                carry = (k > 0) && (((res >> (w - 1)) & 1) != 0);
            end
        endcase
        if (op == 4'd4) begin
            m[sel].flags = {m[sel].flags[7], 1'b0, borrow, lt, gt, eq, (res == 0), 1'b0};
        end else begin
            m[sel].result = res;
            m[sel].valid  = 1'b1;
            m[sel].flags  = {2'b00, borrow, lt, gt, eq, (res == 0), carry};
        end
        lat = (op >= 4'd12 && k > 0) ? k : 0;
`ifdef ALU_BARREL_SHIFT_EN
        lat = 0;
`endif
    endtask

    // Waits (bounded) for cmd_ready, presents one command for the accept edge, returns 1 time unit after it.
    task automatic send(bit sel, logic [3:0] cmd, logic [3:0] op,
                        logic [63:0] a, logic [63:0] b, logic [7:0] fin);
        int   waited = 0;
        obs_t o;
        @(negedge clk);
        o = sample(sel);
        while (!o.ready && waited < 200) begin
            @(negedge clk);
            waited++;
            o = sample(sel);
        end
        if (waited >= 200) check("ready_timeout", {63'd0, o.ready}, 64'd1);
        drive(sel, 1'b1, cmd, op, a, b, fin);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 4'd0, 4'd0, 64'd0, 64'd0, 8'd0);
    endtask

    task automatic do_latch(bit sel, logic [3:0] op, logic [63:0] a, logic [63:0] b, logic [7:0] fin);
        int   lat;
        obs_t o;
        model_latch(sel, op, a, b, fin, lat);
        send(sel, 4'd1, op, a, b, fin);
        for (int i = 0; i < lat; i++) begin
            o = sample(sel);
            check("busy_during_shift", {63'd0, o.busy}, 64'd1);
            check("ready_during_shift", {63'd0, o.ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        o = sample(sel);
        check("busy_after_op", {63'd0, o.busy}, 64'd0);
        check("ready_after_op", {63'd0, o.ready}, 64'd1);
        $display("txn dut%0d LATCHOP op=%h a=%h b=%h fin=%h cycles=%0d -> result=%h flags=%h",
                 sel ? 8 : 16, op, a, b, fin, lat, m[sel].result, m[sel].flags);
    endtask

    task automatic do_writec(bit sel);
        obs_t o;
        send(sel, 4'd2, 4'd0, 64'd0, 64'd0, 8'd0);
        o = sample(sel);
        if (m[sel].valid) begin
            check("c_we_strobe", {63'd0, o.c_we}, 64'd1);
            check("c_data", o.c_data, m[sel].result);
        end else begin
            check("c_we_suppressed", {63'd0, o.c_we}, 64'd0);
            m[sel].flags[7] = 1'b1;
        end
        @(posedge clk);
        #1;
        o = sample(sel);
        check("c_we_one_cycle", {63'd0, o.c_we}, 64'd0);
        $display("txn dut%0d WRITEC -> c_data=%h valid=%0d", sel ? 8 : 16, o.c_data, m[sel].valid);
    endtask

    task automatic do_writef(bit sel);
        obs_t o;
        send(sel, 4'd3, 4'd0, 64'd0, 64'd0, 8'd0);
        o = sample(sel);
        check("f_we_strobe", {63'd0, o.f_we}, 64'd1);
        check("f_data", {56'd0, o.f_data}, {56'd0, m[sel].flags});
        @(posedge clk);
        #1;
        o = sample(sel);
        check("f_we_one_cycle", {63'd0, o.f_we}, 64'd0);
        check("f_data_hold", {56'd0, o.f_data}, {56'd0, m[sel].flags});
        $display("txn dut%0d WRITEF -> f_data=%h", sel ? 8 : 16, o.f_data);
    endtask

    task automatic do_other(bit sel, logic [3:0] cmd);
        obs_t o;
        send(sel, cmd, 4'd0, 64'd0, 64'd0, 8'd0);
        if (cmd >= 4'd4) m[sel].flags[7] = 1'b1;
        o = sample(sel);
        check("no_c_we_on_other", {63'd0, o.c_we}, 64'd0);
        check("no_f_we_on_other", {63'd0, o.f_we}, 64'd0);
        $display("txn dut%0d CMD=%h (no strobe)", sel ? 8 : 16, cmd);
    endtask

    task automatic check_reset_state(bit sel);
        obs_t o = sample(sel);
        check("rst_ready", {63'd0, o.ready}, 64'd1);
        check("rst_busy", {63'd0, o.busy}, 64'd0);
        check("rst_c_we", {63'd0, o.c_we}, 64'd0);
        check("rst_f_we", {63'd0, o.f_we}, 64'd0);
        check("rst_c_data", o.c_data, 64'd0);
        check("rst_f_data", {56'd0, o.f_data}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 64'd0, 8'd0);
        drive(1'b1, 1'b0, 4'd0, 4'd0, 64'd0, 64'd0, 8'd0);
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state(1'b0);
        check_reset_state(1'b1);
        reset = 1'b0;

        // 8-bit signed: carry out of ADD, then strobes
        do_latch(1'b1, 4'd0, 64'hFF, 64'h01, 8'h00);
        do_writec(1'b1);
        do_writef(1'b1);

        // 16-bit: SBB with borrow-in, equal operands
        do_latch(1'b0, 4'd3, 64'h0005, 64'h0005, 8'h20);
        do_writec(1'b0);
        do_writef(1'b0);

        // 16-bit: iterative rotate by 3
        do_latch(1'b0, 4'd14, 64'h8001, 64'd3, 8'h00);
        do_writec(1'b0);
        do_writef(1'b0);

        // Zero-amount shift and max-amount shift
        do_latch(1'b0, 4'd12, 64'hA5A5, 64'h0010, 8'h00);
        do_writef(1'b0);
        do_latch(1'b1, 4'd13, 64'h81, 64'd7, 8'h00);
        do_writec(1'b1);

        // Reset in the middle of a 7-step LSH
        send(1'b0, 4'd1, 4'd12, 64'h1234, 64'd7, 8'h00);
        o = sample(1'b0);
        check("mid_shift_busy", {63'd0, o.busy}, 64'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_state(1'b0);
        check_reset_state(1'b1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            o = sample(1'b0);
            check("no_c_we_after_abort", {63'd0, o.c_we}, 64'd0);
        end

        // Error path after reset: WRITEC without result, illegal command, cleared by ADD
        do_writec(1'b0);
        do_writef(1'b0);
        do_other(1'b0, 4'd4);
        do_writef(1'b0);
        do_other(1'b0, 4'd0);
        do_latch(1'b0, 4'd4, 64'h0003, 64'h0003, 8'h00);
        do_writef(1'b0);
        do_latch(1'b0, 4'd0, 64'h0001, 64'h0002, 8'h00);
        do_writef(1'b0);

        // 8-bit signed CMP leaves the result untouched
        do_latch(1'b1, 4'd8, 64'h3C, 64'h0F, 8'h00);
        do_latch(1'b1, 4'd4, 64'h80, 64'h01, 8'h00);
        do_writef(1'b1);
        do_writec(1'b1);

        for (int it = 0; it < 80; it++) begin
            bit          sel = it[0];
            int unsigned r   = $urandom_range(0, 9);
            logic [63:0] ra, rb;
            case ($urandom_range(0, 3))
                0:       ra = 64'd0;
                1:       ra = '1;
                default: ra = {32'd0, $urandom};
            endcase
            rb = ($urandom_range(0, 2) == 0) ? {32'd0, $urandom} : {60'd0, 4'($urandom_range(0, 15))};
            if (r <= 5)       do_latch(sel, 4'($urandom_range(0, 15)), ra, rb, 8'($urandom));
            else if (r == 6)  do_writec(sel);
            else if (r == 7)  do_writef(sel);
            else if (r == 8)  do_other(sel, 4'd0);
            else              do_other(sel, 4'($urandom_range(4, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
